// File: rtl/psr_flag_unit.sv
// psr_flag_unit: program status register with masked flag writes, condition decode
// and a saturating LIFO shadow stack for interrupt save/restore.
module psr_flag_unit #(
    parameter int FLAGBITS = 5,
    parameter int CONDBITS = 4,
    parameter int DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [FLAGBITS-1:0]     psr_in,
    input  logic [FLAGBITS-1:0]     flag_we,
    input  logic [CONDBITS-1:0]     cond,
    input  logic                    save,
    input  logic                    restore,
    output logic [FLAGBITS-1:0]     psr_out,
    output logic                    cond_true,
    output logic [$clog2(DEPTH):0]  stk_count,
    output logic                    stk_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [FLAGBITS-1:0] stk [DEPTH];
    logic [FLAGBITS-1:0] psr_q;
    logic [CW-1:0]       cnt;
    logic [AW-1:0]       top;
    logic                c, l, f, z, n;
    logic [15:0]         cond_tbl;

    assign top = AW'(cnt - 1'b1);
    assign {c, l, f, z, n} = psr_q[4:0];
    // Bit k of the table is the outcome of condition code k.
    assign cond_tbl = {1'b0, 1'b1, n | z, ~n & ~z, l | z, ~l & ~z, ~f, f,
                       ~n, n, ~l, l, ~c, c, ~z, z};
    assign cond_true = cond_tbl[cond];
    assign psr_out   = psr_q;
    assign stk_count = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q   <= '0;
            cnt     <= '0;
            stk_err <= 1'b0;
        end else if (en) begin
            if (restore && cnt != '0) begin
                psr_q <= stk[top];
                if (save) stk[top] <= psr_q;
                else cnt <= cnt - 1'b1;
            end else begin
                psr_q <= (psr_q & ~flag_we) | (psr_in & flag_we);
                if (restore || (save && cnt == FULL)) stk_err <= 1'b1;
                else if (save) begin
                    stk[cnt[AW-1:0]] <= psr_q;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
